tick_gen: RTL and testbench
===========================

// Module: tick_gen
// PURPOSE
//  Programmable prescaler that produces the 1-cycle 'tick' strobe consumed by traffic_light.
//  It divides clk by a run-time period, with enable/pause, synchronous clear and glitch-free
//  period reload. It sits directly upstream of the controller, and its tick output drives
//  traffic_light.tick.
// PARAMETERS
//  DIV_W       16   width of the period and counter registers
//  DEF_PERIOD  20   period loaded at reset, in clk cycles; must be in the range 1..2^DIV_W-1
// PORTS
//  clk         in   1      system clock; all logic is on posedge
//  rst         in   1      synchronous, active-high reset
//  en          in   1      1 = count, 0 = pause; the count is held while paused
//  clr         in   1      synchronous clear of counter and state (keeps the period)
//  period_ld   in   1      1-cycle strobe: request a new period
//  period_in   in   DIV_W  requested period in cycles; valid when period_ld=1
//  tick        out  1      registered pulse, high for 1 cycle per period
//  busy        out  1      1 when state==RUN
//  period_err  out  1      registered 1-cycle pulse: period_ld was seen with period_in==0
//  cur_period  out  DIV_W  period currently in effect (period_act)
// BEHAVIOUR
//  Reset values: state=IDLE, cnt=0, tick=0, busy=0, period_err=0, period_act=DEF_PERIOD, pend_vld=0.
//  FSM (registered):
//   - IDLE -> RUN when en=1. The same edge counts as the first count (cnt<=1, or a tick if period_act==1).
//   - RUN -> PAUSE when en=0. cnt is held; tick<=0.
//   - PAUSE -> RUN when en=1. Counting resumes from the held cnt on that same edge.
//  Counting rule in RUN with en=1, on every edge:
//   - If cnt==period_act-1: cnt<=0 and tick<=1. If pend_vld=1, also period_act<=pend and pend_vld<=0.
//   - Otherwise: cnt<=cnt+1 and tick<=0.
//  Tick timing:
//   - Ticks occur on the edges numbered P, 2P, 3P, ... counted from the first enabled edge (P = period_act).
//   - Tick is high for exactly 1 cycle, except P=1, where tick stays high on every enabled cycle.
//  Period reload:
//   - period_ld=1 with period_in!=0 while in RUN or PAUSE: pend<=period_in and pend_vld<=1.
//     The new period is applied only at the next wrap, so the current period always completes.
//   - A second period_ld before the wrap overwrites pend (last write wins).
//   - period_ld while in IDLE: period_act<=period_in immediately.
//   - period_in==0: the request is ignored, period_err<=1 for 1 cycle, and state and period are unchanged.
//  clr:
//   - Forces state=IDLE, cnt=0, tick=0 and pend_vld=0, so any pending period is discarded.
//   - period_act is kept.
//   - If clr and period_ld are both high in the same cycle, the load goes directly to period_act (IDLE rule).
//  Priority: rst > clr > counting/loading. Reset mid-period gives the reset values on the next edge.
//  Widths: cnt is DIV_W bits and unsigned. The compare uses period_act-1, computed in DIV_W bits;
//   period_act is never 0, so no underflow occurs.
//  Latency: every output is registered, with 1 cycle from the sampled input to the output change.
// CONFIGURATION
//  TICKGEN_TICK_CNT_EN:
//   - Defined: adds output port tick_cnt [7:0], a free-running count of emitted ticks.
//     It is 0 at rst, held by clr (not cleared), wraps 255 -> 0, and updates on the same edge tick is set.
//   - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  1. rst 5 cycles, then en=1 held, DEF_PERIOD=20
//     -> tick on edges 20, 40, 60 after release; each pulse is 1 cycle wide; busy=1 from edge 1.
//  2. en=1 for 7 edges, en=0 for 10 cycles, then en=1
//     -> no tick during pause; the first tick comes 13 enabled edges after resume; busy=0 while paused.
//  3. At cnt=5 (period 20), period_ld with period_in=4
//     -> the next tick stays 15 edges later; the ticks after it are every 4 edges; cur_period changes 4 at that wrap.
//  4. period_ld with period_in=0 while in RUN
//     -> period_err high for exactly 1 cycle; cur_period stays 20; tick spacing unchanged.
//  5. period_in=1 loaded in IDLE, then en=1
//     -> tick high on every enabled cycle.
//     Then clr=1 at mid-run -> tick=0, busy=0, cnt=0 next cycle; cur_period stays 1.
//  6. With TICKGEN_TICK_CNT_EN: run 256 ticks at period 2
//     -> tick_cnt goes 255 -> 0.
//     Then rst asserted mid-period -> all outputs at reset values one edge later.

Source files
------------

// File: rtl/tick_gen.sv
// tick_gen: programmable prescaler producing a 1-cycle tick strobe every
// period_act enabled clk cycles. It supports pause, synchronous clear and a
// period reload that takes effect at the next wrap.
// Optional feature macro: TICKGEN_TICK_CNT_EN adds the tick_cnt output.
module tick_gen #(
    parameter int DIV_W      = 16,
    parameter int DEF_PERIOD = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             period_ld,
    input  logic [DIV_W-1:0] period_in,
    output logic             tick,
    output logic             busy,
    output logic             period_err,
    output logic [DIV_W-1:0] cur_period
`ifdef TICKGEN_TICK_CNT_EN
    ,
    output logic [7:0]       tick_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEF_P   = DIV_W'(DEF_PERIOD);

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_busy;
    logic             r_err;
    logic [DIV_W-1:0] r_period_act;
    logic [DIV_W-1:0] r_pend;
    logic             r_pend_vld;

    logic [DIV_W-1:0] w_last;
    logic             w_wrap;
    logic             w_ld_ok;
    logic             w_ld_zero;

    // period_act is never 0, so period_act-1 cannot underflow
    assign w_last    = r_period_act - ONE;
    assign w_wrap    = (r_cnt == w_last);
    assign w_ld_ok   = period_ld && (period_in != '0);
    assign w_ld_zero = period_ld && (period_in == '0);

    // Main FSM: counting, pause, clear and period reload; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_tick       <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_period_act <= DEF_P;
            r_pend       <= '0;
            r_pend_vld   <= 1'b0;
        end else if (clr) begin
            // Back to IDLE; a coincident load follows the IDLE rule (direct apply)
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_busy     <= 1'b0;
            r_pend_vld <= 1'b0;
            r_err      <= w_ld_zero;
            if (w_ld_ok)
                r_period_act <= period_in;
        end else begin
            r_err  <= w_ld_zero;
            r_tick <= 1'b0;
            if (en) begin
                // IDLE->RUN and PAUSE->RUN both count on the entering edge
                r_state <= RUN;
                r_busy  <= 1'b1;
                if (w_wrap) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                    if (r_pend_vld) begin
                        r_period_act <= r_pend;
                        r_pend_vld   <= 1'b0;
                    end
                end else begin
                    r_cnt <= r_cnt + ONE;
                end
            end else if (r_state == RUN) begin
                r_state <= PAUSE;
                r_busy  <= 1'b0;
            end
            // Load placed after the wrap so a request on the wrap edge stays pending
            if (w_ld_ok) begin
                if (r_state == IDLE) begin
                    r_period_act <= period_in;
                end else begin
                    r_pend     <= period_in;
                    r_pend_vld <= 1'b1;
                end
            end
        end
    end

    assign tick       = r_tick;
    assign busy       = r_busy;
    assign period_err = r_err;
    assign cur_period = r_period_act;

`ifdef TICKGEN_TICK_CNT_EN
    logic [7:0] r_tick_cnt;

    // Free-running tick counter: cleared only by rst, held through clr
    always_ff @(posedge clk) begin
        if (rst)
            r_tick_cnt <= '0;
        else if (!clr && en && w_wrap)
            r_tick_cnt <= r_tick_cnt + 8'd1;
    end

    assign tick_cnt = r_tick_cnt;
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Directed testbench for tick_gen (default DEF_PERIOD=20, DIV_W=16).
module tb_tick_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        period_ld = 1'b0;
    logic [15:0] period_in = '0;
    logic        tick;
    logic        busy;
    logic        period_err;
    logic [15:0] cur_period;
`ifdef TICKGEN_TICK_CNT_EN
    logic [7:0]  tick_cnt;
`endif

    int total = 0;
    int bad   = 0;

    tick_gen #(.DIV_W(16), .DEF_PERIOD(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .period_ld  (period_ld),
        .period_in  (period_in),
        .tick       (tick),
        .busy       (busy),
        .period_err (period_err),
        .cur_period (cur_period)
`ifdef TICKGEN_TICK_CNT_EN
        ,
        .tick_cnt   (tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One clock edge; inputs are driven and outputs sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        en = 1'b0; clr = 1'b1; step(); clr = 1'b0;
    endtask

    task automatic load_idle(input logic [15:0] p);
        period_ld = 1'b1; period_in = p; step(); period_ld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        repeat (5) step();
        total++;
        if (tick !== 1'b0 || busy !== 1'b0 || period_err !== 1'b0 || cur_period !== 16'd20) begin
            bad++;
            $display("FAIL reset: tick=%b busy=%b err=%b cur=%0d, want 0 0 0 20", tick, busy, period_err, cur_period);
        end
    endtask

    task automatic test_basic();
        rst = 1'b0; en = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            total++;
            if (tick !== (n % 20 == 0)) begin
                bad++;
                $display("FAIL basic_tick edge %0d: got %b want %b", n, tick, (n % 20 == 0));
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_busy edge %0d: got %b want 1", n, busy);
            end
        end
    endtask

    task automatic test_pause();
        do_clr();
        en = 1'b1;
        repeat (7) step();
        en = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            total++;
            if (tick !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL pause cycle %0d: tick=%b busy=%b want 0 0", n, tick, busy);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            total++;
            if (tick !== (k == 13) || busy !== 1'b1) begin
                bad++;
                $display("FAIL resume edge %0d: tick=%b busy=%b want %b 1", k, tick, busy, (k == 13));
            end
        end
    endtask

    task automatic test_reload();
        logic exp_t;
        logic [15:0] exp_p;
        do_clr();
        en = 1'b1;
        repeat (5) step();
        // cnt is now 5; request period 4, then a second write wins over a first
        period_ld = 1'b1; period_in = 16'd9; step();
        period_in = 16'd4;
        for (int k = 2; k <= 23; k++) begin
            step();
            period_ld = 1'b0;
            exp_t = (k == 15) || (k > 15 && (k - 15) % 4 == 0);
            exp_p = (k >= 15) ? 16'd4 : 16'd20;
            total++;
            if (tick !== exp_t || cur_period !== exp_p) begin
                bad++;
                $display("FAIL reload edge %0d: tick=%b cur=%0d want %b %0d", k, tick, cur_period, exp_t, exp_p);
            end
        end
    endtask

    task automatic test_period_err();
        do_clr();
        load_idle(16'd20);
        total++;
        if (cur_period !== 16'd20) begin
            bad++;
            $display("FAIL idle_load: cur=%0d want 20", cur_period);
        end
        en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            period_ld = (k == 8);
            period_in = '0;
            step();
            period_ld = 1'b0;
            total++;
            if (tick !== (k % 20 == 0) || period_err !== (k == 8) || cur_period !== 16'd20) begin
                bad++;
                $display("FAIL period_err edge %0d: tick=%b err=%b cur=%0d want %b %b 20",
                         k, tick, period_err, cur_period, (k % 20 == 0), (k == 8));
            end
        end
    endtask

    task automatic test_p1_clr();
        do_clr();
        load_idle(16'd1);
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            total++;
            if (tick !== 1'b1 || busy !== 1'b1 || cur_period !== 16'd1) begin
                bad++;
                $display("FAIL p1 edge %0d: tick=%b busy=%b cur=%0d want 1 1 1", k, tick, busy, cur_period);
            end
        end
        clr = 1'b1; step(); clr = 1'b0; en = 1'b0;
        total++;
        if (tick !== 1'b0 || busy !== 1'b0 || cur_period !== 16'd1) begin
            bad++;
            $display("FAIL p1_clr: tick=%b busy=%b cur=%0d want 0 0 1", tick, busy, cur_period);
        end
        // clr together with a load applies the load directly
        clr = 1'b1; period_ld = 1'b1; period_in = 16'd3; step();
        clr = 1'b0; period_ld = 1'b0;
        total++;
        if (cur_period !== 16'd3 || tick !== 1'b0) begin
            bad++;
            $display("FAIL clr_load: cur=%0d tick=%b want 3 0", cur_period, tick);
        end
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            total++;
            if (tick !== (k % 3 == 0)) begin
                bad++;
                $display("FAIL clr_load_run edge %0d: got %b want %b", k, tick, (k % 3 == 0));
            end
        end
    endtask

`ifdef TICKGEN_TICK_CNT_EN
    task automatic test_tick_cnt();
        logic [7:0] exp_c;
        rst = 1'b1; step(); rst = 1'b0;
        load_idle(16'd2);
        en = 1'b1;
        exp_c = 8'd0;
        for (int k = 1; k <= 514; k++) begin
            step();
            if (k % 2 == 0) exp_c = exp_c + 8'd1;
            total++;
            if (tick_cnt !== exp_c || tick !== (k % 2 == 0)) begin
                bad++;
                $display("FAIL tick_cnt edge %0d: cnt=%0d tick=%b want %0d %b", k, tick_cnt, tick, exp_c, (k % 2 == 0));
            end
        end
        do_clr();
        total++;
        if (tick_cnt !== 8'd1) begin
            bad++;
            $display("FAIL tick_cnt_clr: got %0d want 1", tick_cnt);
        end
    endtask
`endif

    task automatic test_rst_mid();
        do_clr();
        load_idle(16'd5);
        en = 1'b1;
        repeat (7) step();
        period_ld = 1'b1; period_in = 16'd9; step(); period_ld = 1'b0;
        rst = 1'b1; step();
        total++;
        if (tick !== 1'b0 || busy !== 1'b0 || period_err !== 1'b0 || cur_period !== 16'd20) begin
            bad++;
            $display("FAIL rst_mid: tick=%b busy=%b err=%b cur=%0d want 0 0 0 20", tick, busy, period_err, cur_period);
        end
`ifdef TICKGEN_TICK_CNT_EN
        total++;
        if (tick_cnt !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid_cnt: got %0d want 0", tick_cnt);
        end
`endif
        // pending 9 must have been discarded: next tick at 20
        rst = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            step();
            total++;
            if (tick !== (k == 20) || cur_period !== 16'd20) begin
                bad++;
                $display("FAIL rst_restart edge %0d: tick=%b cur=%0d want %b 20", k, tick, cur_period, (k == 20));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_reload();
        test_period_err();
        test_p1_clr();
`ifdef TICKGEN_TICK_CNT_EN
        test_tick_cnt();
`endif
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
